// File: rtl/macs_seq_ctrl_pkg.sv
// Shared definitions for the Macs sequencer: FSM states, operation modes and lane count.
package macs_seq_ctrl_pkg;

  localparam int LANES = 4;

  localparam logic MODE_MAC = 1'b0;
  localparam logic MODE_ADD = 1'b1;
  localparam logic SIG_ADD  = 1'b0;
  localparam logic SIG_SUB  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    CHK,
    LDC,
    WTC,
    FET,
    ISS,
    WTM,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/macs_seq_ctrl.sv
// Sequencer for the 4-lane Macs unit: walks GRP groups x LEN terms, fetching A/B/C operands,
// issuing one Macs op at a time, chaining results as the next accumulator and writing each group out.
module macs_seq_ctrl
  import macs_seq_ctrl_pkg::*;
#(
  parameter int AW = 10,
  parameter int LW = 11,
  parameter int GW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cfg_mode,
  input  logic                   cfg_signal,
  input  logic [LW-1:0]          cfg_len,
  input  logic [GW-1:0]          cfg_grp,
  input  logic [AW-1:0]          cfg_a_base,
  input  logic [AW-1:0]          cfg_b_base,
  input  logic [AW-1:0]          cfg_c_base,
  input  logic [AW-1:0]          cfg_o_base,
  output logic                   busy,
  output logic                   done,
  output logic                   a_rd_en,
  output logic [AW-1:0]          a_rd_addr,
  input  logic [8*LANES-1:0]     a_rd_data,
  output logic                   b_rd_en,
  output logic [AW-1:0]          b_rd_addr,
  input  logic [16*LANES-1:0]    b_rd_data,
  output logic                   c_rd_en,
  output logic [AW-1:0]          c_rd_addr,
  input  logic [16*LANES-1:0]    c_rd_data,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [16*LANES-1:0]    wr_data,
  output logic                   mac_en,
  output logic                   mac_mode,
  output logic                   mac_signal,
  output logic [8*LANES-1:0]     mac_a,
  output logic [16*LANES-1:0]    mac_b,
  output logic [16*LANES-1:0]    mac_c,
  input  logic [16*LANES-1:0]    mac_result,
  input  logic                   mac_done
);

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_mode;
  logic                  r_signal;
  logic [LW-1:0]         r_len;
  logic [GW-1:0]         r_grp;
  logic [AW-1:0]         r_a_base;
  logic [AW-1:0]         r_b_base;
  logic [AW-1:0]         r_c_base;
  logic [AW-1:0]         r_o_base;

  logic [LW-1:0]         r_k;
  logic [GW-1:0]         r_g;
  logic [AW-1:0]         r_b_ptr;
  logic [16*LANES-1:0]   r_acc;

  logic                  r_mac_en;
  logic [8*LANES-1:0]    r_mac_a;
  logic [16*LANES-1:0]   r_mac_b;
  logic [16*LANES-1:0]   r_mac_c;

  logic [LW-1:0]         w_k_inc;
  logic [GW-1:0]         w_g_inc;
  logic                  w_mac_ack;

  assign w_k_inc = r_k + LW'(1);
  assign w_g_inc = r_g + GW'(1);
  // mac_done is only honoured once the issue pulse has retired, so a result can never pair with a stale op.
  assign w_mac_ack = (r_state == WTM) && mac_done && !r_mac_en;

  always_comb begin
    // NOTE: every always_comb target gets a default before the case, otherwise a missed branch infers a latch.
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (start) w_next_state = CHK;
      CHK:  w_next_state = (r_grp == '0) ? DONE : LDC;
      LDC:  w_next_state = WTC;
      WTC:  w_next_state = (r_len == '0) ? WR : FET;
      FET:  w_next_state = ISS;
      ISS:  w_next_state = WTM;
      WTM:  if (w_mac_ack) w_next_state = (w_k_inc == r_len) ? WR : FET;
      WR:   w_next_state = (w_g_inc == r_grp) ? DONE : LDC;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= 1'b0;
      r_signal <= 1'b0;
      r_len    <= '0;
      r_grp    <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_base <= '0;
      r_o_base <= '0;
      r_k      <= '0;
      r_g      <= '0;
      r_b_ptr  <= '0;
      r_acc    <= '0;
      r_mac_en <= 1'b0;
      r_mac_a  <= '0;
      r_mac_b  <= '0;
      r_mac_c  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_mac_en <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mode   <= cfg_mode;
            r_signal <= cfg_signal;
            r_len    <= cfg_len;
            r_grp    <= cfg_grp;
            r_a_base <= cfg_a_base;
            r_b_base <= cfg_b_base;
            r_c_base <= cfg_c_base;
            r_o_base <= cfg_o_base;
            r_k      <= '0;
            r_g      <= '0;
            r_b_ptr  <= cfg_b_base;
          end
        end
        WTC: r_acc <= c_rd_data;
        ISS: begin
          r_mac_a  <= a_rd_data;
          r_mac_b  <= b_rd_data;
          r_mac_c  <= r_acc;
          r_mac_en <= 1'b1;
        end
        WTM: begin
          if (w_mac_ack) begin
            r_acc   <= mac_result;
            r_k     <= w_k_inc;
            // B is row-major with grp words per row, so the next term of this group is one row down.
            r_b_ptr <= r_b_ptr + AW'(r_grp);
          end
        end
        WR: begin
          r_g     <= w_g_inc;
          r_k     <= '0;
          r_b_ptr <= r_b_base + AW'(w_g_inc);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

  assign c_rd_en   = (r_state == LDC);
  assign c_rd_addr = c_rd_en ? r_c_base + AW'(r_g) : '0;
  assign a_rd_en   = (r_state == FET);
  assign a_rd_addr = a_rd_en ? r_a_base + AW'(r_k) : '0;
  assign b_rd_en   = (r_state == FET);
  assign b_rd_addr = b_rd_en ? r_b_ptr : '0;

  assign wr_en     = (r_state == WR);
  assign wr_addr   = wr_en ? r_o_base + AW'(r_g) : '0;
  assign wr_data   = wr_en ? r_acc : '0;

  assign mac_en     = r_mac_en;
  assign mac_mode   = r_mode;
  assign mac_signal = r_signal;
  assign mac_a      = r_mac_a;
  assign mac_b      = r_mac_b;
  assign mac_c      = r_mac_c;

endmodule

// File: tb/tb_macs_seq_ctrl.sv
// Bench for macs_seq_ctrl: 1-cycle RAM models, a Macs model with random latency and a
// per-group arithmetic reference of the expected output words.
module tb_macs_seq_ctrl;
  import macs_seq_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int LW = 11;
  localparam int GW = 8;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst, start, cfg_mode, cfg_signal;
  logic [LW-1:0] cfg_len;
  logic [GW-1:0] cfg_grp;
  logic [AW-1:0] cfg_a_base, cfg_b_base, cfg_c_base, cfg_o_base;
  logic        busy, done;
  logic        a_rd_en, b_rd_en, c_rd_en, wr_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr, c_rd_addr, wr_addr;
  logic [31:0] a_rd_data = '0;
  logic [63:0] b_rd_data = '0, c_rd_data = '0, wr_data;
  logic        mac_en, mac_mode, mac_signal, mac_done;
  logic [31:0] mac_a;
  logic [63:0] mac_b, mac_c;
  logic [63:0] mac_result = '0;
  logic        m_done = 1'b0, stray_done = 1'b0;

  assign mac_done = m_done | stray_done;

  always #5 clk = ~clk;

  macs_seq_ctrl #(.AW(AW), .LW(LW), .GW(GW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_mode(cfg_mode), .cfg_signal(cfg_signal), .cfg_len(cfg_len), .cfg_grp(cfg_grp),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base), .cfg_o_base(cfg_o_base),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .c_rd_en(c_rd_en), .c_rd_addr(c_rd_addr), .c_rd_data(c_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mac_en(mac_en), .mac_mode(mac_mode), .mac_signal(mac_signal),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_result(mac_result), .mac_done(mac_done)
  );

  logic [31:0] a_mem [DEPTH];
  logic [63:0] b_mem [DEPTH];
  logic [63:0] c_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // RAM models: data valid the cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? a_mem[a_rd_addr] : $urandom;
    b_rd_data <= b_rd_en ? b_mem[b_rd_addr] : {$urandom, $urandom};
    c_rd_data <= c_rd_en ? c_mem[c_rd_addr] : {$urandom, $urandom};
  end

  function automatic logic [63:0] macs_fn(logic [31:0] a, logic [63:0] b, logic [63:0] c,
                                          logic mode, logic sig);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) begin
      logic [15:0] am;
      logic [15:0] t;
      am = (mode == MODE_ADD) ? 16'd1 : {8'd0, a[8*l +: 8]};
      t  = am * b[16*l +: 16];
      r[16*l +: 16] = (sig == SIG_SUB) ? c[16*l +: 16] - t : c[16*l +: 16] + t;
    end
    return r;
  endfunction

  // Macs model: captures operands on mac_en, answers 1-4 cycles later.
  int          m_wait = 0;
  int          n_overlap = 0;
  int          n_unstable = 0;
  logic [31:0] m_a;
  logic [63:0] m_b, m_c, m_res;
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_wait = 0;
    end else begin
      if (mac_en && m_wait > 0) n_overlap++;
      if (m_wait > 0) begin
        if (mac_a !== m_a || mac_b !== m_b || mac_c !== m_c) n_unstable++;
        m_wait--;
        if (m_wait == 0) begin
          m_done     <= 1'b1;
          mac_result <= m_res;
        end
      end else if (mac_en) begin
        m_a = mac_a;
        m_b = mac_b;
        m_c = mac_c;
        m_res = macs_fn(mac_a, mac_b, mac_c, mac_mode, mac_signal);
        m_wait = $urandom_range(1, 4);
      end
    end
  end

  // Monitor: running totals sampled mid-cycle; tasks take snapshots and look at differences.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_a_rd = 0, n_b_rd = 0, n_c_rd = 0, n_done = 0, n_mac = 0;
  int wr_cyc = 0, done_cyc = 0;
  logic last_mac_mode = 1'b0;
  logic [AW-1:0] b_addr_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [63:0]   wr_data_q[$];
  always @(negedge clk) begin
    if (a_rd_en) n_a_rd++;
    if (b_rd_en) begin n_b_rd++; b_addr_q.push_back(b_rd_addr); end
    if (c_rd_en) n_c_rd++;
    if (wr_en) begin wr_addr_q.push_back(wr_addr); wr_data_q.push_back(wr_data); wr_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (mac_en) begin n_mac++; last_mac_mode = mac_mode; end
  end

  int s_a, s_b, s_c, s_done, s_mac, s_wr, s_bq, start_cyc;
  bit j_mode, j_sig;
  int j_len, j_grp, j_ab, j_bb, j_cb, j_ob;

  task automatic snapshot();
    s_a = n_a_rd; s_b = n_b_rd; s_c = n_c_rd; s_done = n_done; s_mac = n_mac;
    s_wr = wr_addr_q.size(); s_bq = b_addr_q.size();
  endtask

  task automatic fill_mems();
    for (int i = 0; i < DEPTH; i++) begin
      a_mem[i] = $urandom;
      b_mem[i] = {$urandom, $urandom};
      c_mem[i] = {$urandom, $urandom};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Expected output word of group g: C plus/minus the sum of a*b over all terms, lane-wise mod 2^16.
  function automatic logic [63:0] ref_group(int g);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) begin
      int acc;
      acc = int'(c_mem[(j_cb + g) % DEPTH][16*l +: 16]);
      for (int k = 0; k < j_len; k++) begin
        int a;
        int b;
        a = j_mode ? 1 : int'(a_mem[(j_ab + k) % DEPTH][8*l +: 8]);
        b = int'(b_mem[(j_bb + k * j_grp + g) % DEPTH][16*l +: 16]);
        acc = j_sig ? acc - a * b : acc + a * b;
      end
      r[16*l +: 16] = acc[15:0];
    end
    return r;
  endfunction

  task automatic run_job(input bit mode, input bit sig, input int len, input int grp,
                         input int ab, input int bb, input int cb, input int ob, input bit poke);
    bit seen;
    j_mode = mode; j_sig = sig; j_len = len; j_grp = grp;
    j_ab = ab; j_bb = bb; j_cb = cb; j_ob = ob;
    snapshot();
    @(posedge clk); #1;
    cfg_mode = mode; cfg_signal = sig; cfg_len = LW'(len); cfg_grp = GW'(grp);
    cfg_a_base = AW'(ab); cfg_b_base = AW'(bb); cfg_c_base = AW'(cb); cfg_o_base = AW'(ob);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = 1'($urandom); cfg_signal = 1'($urandom); cfg_len = LW'($urandom);
    cfg_grp = GW'($urandom); cfg_a_base = AW'($urandom); cfg_b_base = AW'($urandom);
    cfg_c_base = AW'($urandom); cfg_o_base = AW'($urandom);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_after_start: got %b expected 1", busy);
    end
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 2) start = 1'b1;
      if (poke && i == 3) start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: no done within 3000 cycles (len=%0d grp=%0d)", len, grp);
      do_reset();
    end else begin
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_errors++;
        $display("FAIL idle_after_done: got busy,done=%b expected 00", {busy, done});
      end
    end
  endtask

  task automatic verify_job(input string tag);
    int nw;
    int idx;
    nw = wr_addr_q.size() - s_wr;
    n_checks++;
    if (n_done - s_done != 1) begin
      n_errors++;
      $display("FAIL %s done_count: got %0d expected 1", tag, n_done - s_done);
    end
    n_checks++;
    if (nw != j_grp) begin
      n_errors++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, nw, j_grp);
    end
    for (int g = 0; g < j_grp && g < nw; g++) begin
      n_checks++;
      if (wr_addr_q[s_wr + g] !== AW'((j_ob + g) % DEPTH)) begin
        n_errors++;
        $display("FAIL %s wr_addr[%0d]: got %h expected %h", tag, g, wr_addr_q[s_wr + g],
                 AW'((j_ob + g) % DEPTH));
      end
      n_checks++;
      if (wr_data_q[s_wr + g] !== ref_group(g)) begin
        n_errors++;
        $display("FAIL %s wr_data[%0d]: got %h expected %h", tag, g, wr_data_q[s_wr + g], ref_group(g));
      end
    end
    n_checks++;
    if (n_a_rd - s_a != j_grp * j_len || n_mac - s_mac != j_grp * j_len || n_c_rd - s_c != j_grp) begin
      n_errors++;
      $display("FAIL %s access_counts: got a=%0d mac=%0d c=%0d expected a=mac=%0d c=%0d", tag,
               n_a_rd - s_a, n_mac - s_mac, n_c_rd - s_c, j_grp * j_len, j_grp);
    end
    n_checks++;
    if (b_addr_q.size() - s_bq != j_grp * j_len) begin
      n_errors++;
      $display("FAIL %s b_read_count: got %0d expected %0d", tag, b_addr_q.size() - s_bq, j_grp * j_len);
    end
    idx = s_bq;
    for (int g = 0; g < j_grp; g++) begin
      for (int k = 0; k < j_len; k++) begin
        if (idx < b_addr_q.size()) begin
          n_checks++;
          if (b_addr_q[idx] !== AW'((j_bb + k * j_grp + g) % DEPTH)) begin
            n_errors++;
            $display("FAIL %s b_addr g=%0d k=%0d: got %h expected %h", tag, g, k, b_addr_q[idx],
                     AW'((j_bb + k * j_grp + g) % DEPTH));
          end
        end
        idx++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, a_rd_en, b_rd_en, c_rd_en, wr_en, mac_en, mac_mode, mac_signal} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {busy, done, a_rd_en, b_rd_en, c_rd_en, wr_en, mac_en, mac_mode, mac_signal});
    end
    n_checks++;
    if ({a_rd_addr, b_rd_addr, c_rd_addr, wr_addr, wr_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_addr: got %h expected 0", {a_rd_addr, b_rd_addr, c_rd_addr, wr_addr, wr_data});
    end
    n_checks++;
    if ({mac_a, mac_b, mac_c} !== '0) begin
      n_errors++;
      $display("FAIL reset_mac_ops: got %h expected 0", {mac_a, mac_b, mac_c});
    end
    rst = 1'b0;
  endtask

  task automatic test_mac();
    logic [63:0] got;
    a_mem[5] = 32'h0202_0202;
    a_mem[6] = 32'h0101_0101;
    b_mem[20] = {4{16'h0003}};
    b_mem[21] = {4{16'h0010}};
    c_mem[40] = {4{16'h0001}};
    run_job(MODE_MAC, SIG_ADD, 2, 1, 5, 20, 40, 60, 1'b0);
    verify_job("mac");
    got = (wr_data_q.size() > s_wr) ? wr_data_q[s_wr] : 'x;
    n_checks++;
    if (got !== 64'h0017_0017_0017_0017) begin
      n_errors++;
      $display("FAIL mac_value: got %h expected 0017001700170017", got);
    end
    n_checks++;
    if (done_cyc != wr_cyc + 1) begin
      n_errors++;
      $display("FAIL mac_done_timing: got done at %0d expected %0d", done_cyc, wr_cyc + 1);
    end
  endtask

  task automatic test_sub_wrap();
    logic [63:0] got;
    a_mem[100] = 32'h0101_0101;
    b_mem[200] = {4{16'h0001}};
    c_mem[300] = '0;
    run_job(MODE_MAC, SIG_SUB, 1, 1, 100, 200, 300, 400, 1'b0);
    verify_job("sub_wrap");
    got = (wr_data_q.size() > s_wr) ? wr_data_q[s_wr] : 'x;
    n_checks++;
    if (got !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_errors++;
      $display("FAIL sub_wrap_value: got %h expected ffffffffffffffff", got);
    end
  endtask

  task automatic test_add();
    logic [63:0] got;
    b_mem[210] = {4{16'h0002}};
    c_mem[310] = {4{16'hFFFF}};
    run_job(MODE_ADD, SIG_ADD, 1, 1, 110, 210, 310, 410, 1'b0);
    verify_job("add");
    got = (wr_data_q.size() > s_wr) ? wr_data_q[s_wr] : 'x;
    n_checks++;
    if (got !== 64'h0001_0001_0001_0001) begin
      n_errors++;
      $display("FAIL add_value: got %h expected 0001000100010001", got);
    end
    n_checks++;
    if (last_mac_mode !== 1'b1) begin
      n_errors++;
      $display("FAIL add_mac_mode: got %b expected 1", last_mac_mode);
    end
  endtask

  task automatic test_edges();
    run_job(MODE_MAC, SIG_ADD, 0, 3, 7, 8, 1022, 500, 1'b0);
    verify_job("len0");
    run_job(MODE_MAC, SIG_ADD, 4, 0, 7, 8, 9, 10, 1'b0);
    verify_job("grp0");
    n_checks++;
    if (done_cyc - start_cyc > 3) begin
      n_errors++;
      $display("FAIL grp0_latency: got %0d cycles expected <= 3", done_cyc - start_cyc);
    end
    n_checks++;
    if (n_b_rd - s_b != 0 || wr_addr_q.size() - s_wr != 0) begin
      n_errors++;
      $display("FAIL grp0_accesses: got b=%0d wr=%0d expected 0", n_b_rd - s_b, wr_addr_q.size() - s_wr);
    end
  endtask

  task automatic test_multi_group();
    run_job(MODE_MAC, SIG_ADD, 3, 4, 1020, 1018, 1021, 1022, 1'b0);
    verify_job("multi_group");
  endtask

  task automatic test_random_jobs();
    for (int n = 0; n < 8; n++) begin
      fill_mems();
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
              $urandom_range(1, 4), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b0);
      verify_job("random");
    end
  endtask

  task automatic test_robustness();
    bit seen;
    // reset while waiting on Macs
    snapshot();
    @(posedge clk); #1;
    cfg_mode = MODE_ADD; cfg_signal = SIG_SUB; cfg_len = LW'(3); cfg_grp = GW'(2);
    cfg_a_base = 10'd1; cfg_b_base = 10'd2; cfg_c_base = 10'd3; cfg_o_base = 10'd4;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mac_en === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL wtm_reach: got no mac_en within 50 cycles expected one");
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, a_rd_en, b_rd_en, c_rd_en, wr_en, mac_en, mac_mode, mac_signal} !== 9'd0) begin
      n_errors++;
      $display("FAIL wtm_reset_ctrl: got %b expected 0",
               {busy, done, a_rd_en, b_rd_en, c_rd_en, wr_en, mac_en, mac_mode, mac_signal});
    end
    n_checks++;
    if ({mac_a, mac_b, mac_c, a_rd_addr, b_rd_addr, c_rd_addr, wr_addr, wr_data} !== '0) begin
      n_errors++;
      $display("FAIL wtm_reset_data: got nonzero %h expected 0", {mac_a, mac_b, mac_c});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() - s_wr != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wtm_reset_aftermath: got writes=%0d busy=%b expected 0/0", wr_addr_q.size() - s_wr, busy);
    end

    // start and reset together
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; cfg_grp = GW'(2); cfg_len = LW'(1);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_start_same_cycle: got busy=%b expected 0", busy);
    end

    // stray mac_done while idle
    snapshot();
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || n_mac - s_mac != 0 || wr_addr_q.size() - s_wr != 0) begin
      n_errors++;
      $display("FAIL stray_mac_done: got busy=%b mac=%0d wr=%0d expected 0/0/0",
               busy, n_mac - s_mac, wr_addr_q.size() - s_wr);
    end
    fill_mems();
    run_job(MODE_MAC, SIG_SUB, 2, 2, 50, 60, 70, 80, 1'b0);
    verify_job("after_stray");

    // start while busy
    run_job(MODE_MAC, SIG_ADD, 2, 2, 900, 910, 920, 930, 1'b1);
    verify_job("start_while_busy");
  endtask

  task automatic test_macs_protocol();
    n_checks++;
    if (n_overlap != 0 || n_unstable != 0) begin
      n_errors++;
      $display("FAIL macs_protocol: got overlap=%0d unstable=%0d expected 0/0", n_overlap, n_unstable);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_signal = 1'b0; cfg_len = '0; cfg_grp = '0;
    cfg_a_base = '0; cfg_b_base = '0; cfg_c_base = '0; cfg_o_base = '0;
    fill_mems();
    test_reset();
    test_mac();
    test_sub_wrap();
    test_add();
    test_edges();
    test_multi_group();
    test_random_jobs();
    test_robustness();
    test_macs_protocol();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
